alu_seg_display: RTL
====================

ALU_SEG_DISPLAY -- requirements
Module: alu_seg_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clk cycles per digit scan step (min 2).
REQ-002 SHALL have parameter HOLD_CYC, default 1000: minimum cycles a captured result is held before another is accepted (min 1).
REQ-003 SHALL have parameter BLINK_DIV, default 64: full 4-digit scan frames per blink phase (min 1).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 res_valid  input  1  result word offered.
REQ-007 res_data  input  16  ALU result word: [3:0] sum, [4] cout, [5] overflow, [9:6] logic, [15:10] zero padding, ignored.
REQ-008 res_ready  output  1  block accepts res_data this cycle.
REQ-009 seg  output  8  active-low segments, [6:0]=g..a, [7]=dp.
REQ-010 an  output  4  active-low digit enables, an[0] rightmost.

Function
REQ-011 Transfer SHALL occur on a rising edge with res_valid=1 and res_ready=1; res_data is then latched into the result register (sum, cout, overflow, logic).
REQ-012 FSM SHALL have states IDLE (nothing captured), HOLD, SHOW.
REQ-013 IDLE: res_ready=1; transfer -> HOLD.
REQ-014 HOLD: res_ready=0; hold counter counts from 0; at HOLD_CYC-1 -> SHOW; res_valid ignored.
REQ-015 SHOW: res_ready=1; transfer -> HOLD with hold counter restarted at 0; otherwise stay.
REQ-016 Scan counter SHALL free-run 0..SCAN_DIV-1; on wrap digit index 0..3 increments, 3 wraps to 0; transfers SHALL NOT reset it.
REQ-017 Digit content: 0 = hex(sum), 1 = hex(logic), 2 = hex({3'b0,cout}), 3 = hex({3'b0,overflow}).
REQ-018 dp (seg[7]) SHALL be lit (0) only on digit 0 when latched sum == 4'h0.
REQ-019 seg/an SHALL be registered: they reflect latch and digit index of the previous cycle (1-cycle latency after the accepting edge).
REQ-020 In IDLE an=4'hF and seg=8'hFF; otherwise exactly one an bit low (the current index).
REQ-021 Hex decode SHALL be the standard 0-F patterns (0 -> 7'b1000000, b/d lowercase).
REQ-022 Counter widths SHALL be $clog2 of their parameter; no counter exceeds its terminal value.

Reset
REQ-023 rst=1 SHALL force: state IDLE, result register 0, scan/hold/blink counters 0, digit index 0, res_ready=0, seg=8'hFF, an=4'hF.
REQ-024 Reset mid-HOLD or mid-SHOW SHALL discard the latched result; res_ready=1 first cycle after rst deasserts.

Configuration
REQ-025 Macro ALU_SEG_OVF_BLINK_EN defined: blink phase toggles every BLINK_DIV digit-index wraps 3->0; when phase=1 and latched overflow=1, an SHALL be forced to 4'hF.
REQ-026 Macro undefined: no blink counter exists; display steady regardless of overflow; BLINK_DIV unused.

Structure
REQ-027 Package alu_disp_pkg SHALL hold res_data field positions, FSM state typedef, and 16-entry hex-to-segment constant table.
REQ-028 Combinational sub-module seg7_hex_dec (4-bit in, 7-bit active-low out) SHALL be instantiated once on the muxed nibble.

Verification (SCAN_DIV=4, HOLD_CYC=8, BLINK_DIV=2)
REQ-029 Reset, no valid -> an=4'hF, seg=8'hFF, res_ready=1 after rst drops.
REQ-030 res_data=16'h0019 (sum 9, cout 1) accepted -> res_ready=0 for 8 cycles; digit0 seg=7'b0010000, digit2 shows 1, dp off.
REQ-031 res_valid held high with 16'h0005 then 16'h000A -> second word accepted exactly 8 cycles after first, never earlier.
REQ-032 res_data=16'h0030 (sum 0, overflow 1), macro on -> dp lit on digit 0; an all-high during alternate 2-frame periods; macro off -> never all-high.
REQ-033 rst asserted during HOLD -> next cycle IDLE, blank display, latched values 0.
REQ-034 Free run 64 cycles in SHOW -> an sequence 1110,1101,1011,0111 each for 4 cycles, repeating.

Source files
------------

// File: rtl/alu_disp_pkg.sv
// Shared definitions for the ALU result seven-segment display:
// result word field positions, FSM states and the hex glyph table.
package alu_disp_pkg;

  localparam int SUM_LSB   = 0;
  localparam int COUT_BIT  = 4;
  localparam int OVF_BIT   = 5;
  localparam int LOGIC_LSB = 6;
  localparam int RES_BITS  = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_SHOW
  } state_t;

  typedef struct packed {
    logic [3:0] lgc;
    logic       ovf;
    logic       cout;
    logic [3:0] sum;
  } res_t;

  // Active-low glyphs, bit order g..a
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic res_t unpack_res(
    input logic [RES_BITS-1:0] d
  );
    res_t r;
    r.sum  = d[SUM_LSB +: 4];
    r.cout = d[COUT_BIT];
    r.ovf  = d[OVF_BIT];
    r.lgc  = d[LOGIC_LSB +: 4];
    return r;
  endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex nibble to active-low
// seven-segment glyph decoder.
module seg7_hex_dec
  import alu_disp_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX_SEG[hex];
  end

endmodule

// File: rtl/alu_seg_display.sv
// Captures ALU result words and scans them onto a 4-digit display.
// Optional overflow blink: define ALU_SEG_OVF_BLINK_EN.
module alu_seg_display
  import alu_disp_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int HOLD_CYC  = 1000,
  parameter int BLINK_DIV = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        res_valid,
  input  logic [15:0] res_data,
  output logic        res_ready,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  localparam int SW =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HW =
    (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  state_t         state;
  state_t         state_nx;
  logic [HW-1:0]  hold_cnt;
  logic [HW-1:0]  hold_nx;
  res_t           res_q;
  logic [SW-1:0]  scan_cnt;
  logic           scan_last;
  logic [1:0]     idx;
  logic           frame_wrap;
  logic           xfer;
  logic           blank;
  logic [3:0]     nib;
  logic [6:0]     glyph;
  logic           dp_n;
  logic           unused_pad;

  assign unused_pad = ^res_data[15:RES_BITS];

  assign res_ready = ~rst & (state != ST_HOLD);
  assign xfer      = res_valid & res_ready;

  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    unique case (1'b1)
      (state == ST_IDLE),
      (state == ST_SHOW): begin
        if (xfer) begin
          state_nx = ST_HOLD;
          hold_nx  = '0;
        end
      end
      (state == ST_HOLD): begin
        if (hold_cnt == HW'(HOLD_CYC - 1)) begin
          state_nx = ST_SHOW;
        end else begin
          hold_nx = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      res_q    <= '0;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_nx;
      if (xfer) begin
        res_q <= unpack_res(res_data[RES_BITS-1:0]);
      end
    end
  end

  assign scan_last  = (scan_cnt == SW'(SCAN_DIV - 1));
  assign frame_wrap = scan_last & (idx == 2'd3);

  // Scan timing free-runs; captures never disturb it
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_last) begin
      scan_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

`ifdef ALU_SEG_OVF_BLINK_EN
  localparam int BW =
    (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt;
  logic          blink_ph;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (frame_wrap) begin
      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign blank = blink_ph & res_q.ovf;
`else
  logic unused_blink;

  assign unused_blink = frame_wrap
                      ^ (BLINK_DIV > 0);
  assign blank = 1'b0;
`endif

  always_comb begin
    nib = res_q.sum;
    case (idx)
      2'd0: nib = res_q.sum;
      2'd1: nib = res_q.lgc;
      2'd2: nib = {3'b000, res_q.cout};
      2'd3: nib = {3'b000, res_q.ovf};
      default: nib = res_q.sum;
    endcase
  end

  seg7_hex_dec u_dec (
    .hex (nib),
    .seg (glyph)
  );

  // Decimal point flags a zero sum on the rightmost digit
  assign dp_n = ~((idx == 2'd0) & (res_q.sum == 4'h0));

  always_ff @(posedge clk) begin
    if (rst || state == ST_IDLE) begin
      seg <= 8'hFF;
      an  <= 4'hF;
    end else begin
      seg <= {dp_n, glyph};
      an  <= blank ? 4'hF : ~(4'b0001 << idx);
    end
  end

endmodule
